route_sequencer: RTL and testbench

ROUTE_SEQUENCER -- requirements
Module: route_sequencer

---
 rtl/route_sequencer.sv | 243 ++++++++++++++++++++++++
 tb/tb_route_sequencer.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/route_sequencer.sv
// route_sequencer
//
// Executes a stored route of line-following steps. Steps are loaded while
// idle, then replayed on start: each step follows the line until enough
// crossings have been counted, then goes straight on, turns left/right until
// the line is reacquired, or dwells at a station.
//
// Ports
//   clk                     clock, all logic on the rising edge
//   reset                   synchronous, active-high reset
//   load_valid/load_data    route-step write {action[3:2], target[1:0]}
//                           action 0=STRAIGHT 1=LEFT 2=RIGHT 3=STATION
//   load_ready              write accepted when load_valid && load_ready
//   clear_route             empties route storage (IDLE only)
//   start                   begin executing the stored route
//   sensor_l/m/r            line sensors, 0 = line seen
//   crossing_counter        external crossing count since its last reset
//   reset_crossing_counter  one-cycle pulse, external counter to 0
//   reset_station           one-cycle pulse, external counter to 1
//   drive_cmd               0=HALT 1=FOLLOW 2=TURN_L 3=TURN_R 4=STOP
//   step_idx                index of the step being executed
//   busy                    high in every state except IDLE
//   done                    one-cycle pulse on route completion
//   fault                   turn timeout, held until reset
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | accepts loads / clear, waits for start
// ARM      | one cycle, zeroes the external crossing counter
// FOLLOW   | follows the line until crossing_counter reaches the target
// TURN     | turns until the line is reacquired (sensors 101) or timeout
// STATION  | stopped at a station for STOP_CYCLES cycles
// FINISH   | one cycle, done pulse, back to IDLE
// FAULT    | turn timed out, halted until reset

module route_sequencer #(
    parameter int DEPTH       = 8,
    parameter int TURN_MIN    = 2_000_000,
    parameter int TURN_MAX    = 20_000_000,
    parameter int STOP_CYCLES = 50_000_000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_valid,
    input  logic [3:0]               load_data,
    output logic                     load_ready,
    input  logic                     clear_route,
    input  logic                     start,
    input  logic                     sensor_l,
    input  logic                     sensor_m,
    input  logic                     sensor_r,
    input  logic [1:0]               crossing_counter,
    output logic                     reset_crossing_counter,
    output logic                     reset_station,
    output logic [2:0]               drive_cmd,
    output logic [$clog2(DEPTH)-1:0] step_idx,
    output logic                     busy,
    output logic                     done,
    output logic                     fault
);

    localparam int IW   = $clog2(DEPTH);
    localparam int CW   = IW + 1;
    localparam int TMAX = (TURN_MAX > STOP_CYCLES) ? TURN_MAX : STOP_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] TURN_MIN_T  = TW'(TURN_MIN);
    // Last cycle of TURN/STATION: the timer counts 0..N-1 while in the state.
    localparam logic [TW-1:0] TURN_LAST_T = TW'(TURN_MAX - 1);
    localparam logic [TW-1:0] STOP_LAST_T = TW'(STOP_CYCLES - 1);

    localparam logic [1:0] ACT_STRAIGHT = 2'd0;
    localparam logic [1:0] ACT_LEFT     = 2'd1;
    localparam logic [1:0] ACT_RIGHT    = 2'd2;
    localparam logic [1:0] ACT_STATION  = 2'd3;

    localparam logic [2:0] CMD_HALT   = 3'd0;
    localparam logic [2:0] CMD_FOLLOW = 3'd1;
    localparam logic [2:0] CMD_TURN_L = 3'd2;
    localparam logic [2:0] CMD_TURN_R = 3'd3;
    localparam logic [2:0] CMD_STOP   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_FOLLOW,
        ST_TURN,
        ST_STATION,
        ST_FINISH,
        ST_FAULT
    } state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  step_idx_q, step_idx_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [CW-1:0]  count_q;
    logic [IW-1:0]  wr_ptr_q;
    logic [3:0]     route_mem [DEPTH];

    logic [3:0]     cur_step;
    logic [1:0]     action;
    logic [1:0]     eff_target;
    logic [2:0]     sensors;
    logic           last_step;
    logic           advance;
    logic           load_accept;
    logic           clear_accept;

    assign cur_step   = route_mem[step_idx_q];
    assign action     = cur_step[3:2];
    // A target of 0 would dispatch immediately on the freshly cleared
    // counter, so it is treated as "next crossing".
    assign eff_target = (cur_step[1:0] == 2'd0) ? 2'd1 : cur_step[1:0];
    assign sensors    = {sensor_l, sensor_m, sensor_r};
    assign last_step  = ({1'b0, step_idx_q} == (count_q - CW'(1)));

    assign load_ready   = (state_q == ST_IDLE) && (count_q < CW'(DEPTH));
    // start and clear_route both pre-empt a load presented in the same cycle.
    assign clear_accept = (state_q == ST_IDLE) && clear_route && !start;
    assign load_accept  = load_valid && load_ready && !start && !clear_route;

    assign busy     = (state_q != ST_IDLE);
    assign fault    = (state_q == ST_FAULT);
    assign step_idx = step_idx_q;

    always_comb begin
        state_d                = state_q;
        step_idx_d             = step_idx_q;
        timer_d                = timer_q;
        drive_cmd              = CMD_HALT;
        reset_crossing_counter = 1'b0;
        reset_station          = 1'b0;
        done                   = 1'b0;
        advance                = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    step_idx_d = '0;
                    state_d    = (count_q == '0) ? ST_FINISH : ST_ARM;
                end
            end

            ST_ARM: begin
                drive_cmd              = CMD_FOLLOW;
                reset_crossing_counter = 1'b1;
                state_d                = ST_FOLLOW;
            end

            ST_FOLLOW: begin
                drive_cmd = CMD_FOLLOW;
                if (crossing_counter >= eff_target) begin
                    case (action)
                        ACT_STRAIGHT: advance = 1'b1;
                        ACT_LEFT, ACT_RIGHT: begin
                            timer_d = '0;
                            state_d = ST_TURN;
                        end
                        default: begin
                            timer_d = '0;
                            state_d = ST_STATION;
                        end
                    endcase
                end
            end

            ST_TURN: begin
                drive_cmd = (action == ACT_LEFT) ? CMD_TURN_L : CMD_TURN_R;
                // Reacquiring the line wins over the timeout in the final cycle.
                if ((timer_q >= TURN_MIN_T) && (sensors == 3'b101)) begin
                    advance = 1'b1;
                end else if (timer_q >= TURN_LAST_T) begin
                    state_d = ST_FAULT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            ST_STATION: begin
                drive_cmd = CMD_STOP;
                if (timer_q >= STOP_LAST_T) begin
                    reset_station = 1'b1;
                    advance       = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            ST_FINISH: begin
                done       = 1'b1;
                step_idx_d = '0;
                state_d    = ST_IDLE;
            end

            ST_FAULT: begin
                state_d = ST_FAULT;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (advance) begin
            if (last_step) begin
                step_idx_d = '0;
                state_d    = ST_FINISH;
            end else begin
                step_idx_d = step_idx_q + IW'(1);
                state_d    = ST_ARM;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            step_idx_q <= '0;
            timer_q    <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            step_idx_q <= step_idx_d;
            timer_q    <= timer_d;
            if (clear_accept) begin
                count_q  <= '0;
                wr_ptr_q <= '0;
            end else if (load_accept) begin
                count_q  <= count_q + CW'(1);
                wr_ptr_q <= wr_ptr_q + IW'(1);
            end
        end
    end

    // Storage is not reset; count alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (load_accept) begin
            route_mem[wr_ptr_q] <= load_data;
        end
    end

endmodule

// File: tb/tb_route_sequencer.sv
// Self-checking bench for route_sequencer. A plant model reacts to the
// drive commands (crossing counter, line sensors) following a per-step plan;
// the reference model turns the stored route plus that plan into a timed list
// of expected events, and a monitor compares the events the DUT produces.
module tb_route_sequencer;

    localparam int DEPTH       = 4;
    localparam int TURN_MIN    = 5;
    localparam int TURN_MAX    = 20;
    localparam int STOP_CYCLES = 6;
    localparam int NEVER       = 1000;

    localparam int EV_ARM = 0, EV_TURN = 1, EV_STN = 2, EV_DONE = 3, EV_FAULT = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load_valid = 1'b0;
    logic [3:0] load_data = '0;
    logic       load_ready;
    logic       clear_route = 1'b0;
    logic       start = 1'b0;
    logic       sensor_l = 1'b1, sensor_m = 1'b1, sensor_r = 1'b1;
    logic [1:0] crossing_counter = '0;
    logic       reset_crossing_counter, reset_station;
    logic [2:0] drive_cmd;
    logic [1:0] step_idx;
    logic       busy, done, fault;

    route_sequencer #(
        .DEPTH(DEPTH), .TURN_MIN(TURN_MIN), .TURN_MAX(TURN_MAX), .STOP_CYCLES(STOP_CYCLES)
    ) dut (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .clear_route(clear_route), .start(start),
        .sensor_l(sensor_l), .sensor_m(sensor_m), .sensor_r(sensor_r),
        .crossing_counter(crossing_counter),
        .reset_crossing_counter(reset_crossing_counter), .reset_station(reset_station),
        .drive_cmd(drive_cmd), .step_idx(step_idx),
        .busy(busy), .done(done), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int cyc;
        int idx;
        int cmd;
        bit chk_idx;
    } ev_t;

    ev_t        expq[$];
    logic [3:0] mroute[$];
    int         pg[DEPTH];
    int         pd[DEPTH];
    int         pstep = -1;
    int         cyc = 0;
    int         n_vec = 0;
    int         n_miss = 0;
    bit         mon_en = 1'b0;

    always @(posedge clk) cyc = cyc + 1;

    function automatic string ev_name(int k);
        case (k)
            EV_ARM:  return "arm";
            EV_TURN: return "turn";
            EV_STN:  return "station";
            EV_DONE: return "done";
            default: return "fault";
        endcase
    endfunction

    function automatic void push(int k, int c, int i, int cmd, bit ci);
        ev_t e;
        e.kind = k; e.cyc = c; e.idx = i; e.cmd = cmd; e.chk_idx = ci;
        expq.push_back(e);
    endfunction

    task automatic check(string name, int got, int exp);
        n_vec++;
        if (got != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    task automatic observe(int k);
        ev_t e;
        bit  ok;
        n_vec++;
        if (expq.size() == 0) begin
            n_miss++;
            $display("FAIL unexpected_%s: cyc=%0d idx=%0d cmd=%0d, required no event",
                     ev_name(k), cyc, step_idx, drive_cmd);
            return;
        end
        e  = expq.pop_front();
        ok = (e.kind == k) && (e.cyc == cyc) && (e.cmd == int'(drive_cmd)) &&
             (!e.chk_idx || e.idx == int'(step_idx)) && (k != EV_FAULT || busy);
        if (!ok) begin
            n_miss++;
            $display("FAIL ev_%s: got %s cyc=%0d idx=%0d cmd=%0d busy=%0d, required %s cyc=%0d idx=%0d cmd=%0d",
                     ev_name(e.kind), ev_name(k), cyc, step_idx, drive_cmd, busy,
                     ev_name(e.kind), e.cyc, e.idx, e.cmd);
        end
    endtask

    // Monitor: derives events from DUT outputs, pops and compares.
    bit fault_q = 1'b0, turn_q = 1'b0;
    always @(negedge clk) begin
        bit is_turn;
        is_turn = (drive_cmd == 3'd2) || (drive_cmd == 3'd3);
        if (mon_en) begin
            if (reset_crossing_counter || reset_station)
                check("pulse_exclusive", int'(reset_crossing_counter && reset_station), 0);
            if (reset_crossing_counter) observe(EV_ARM);
            if (reset_station)          observe(EV_STN);
            if (done)                   observe(EV_DONE);
            if (fault && !fault_q)      observe(EV_FAULT);
            if (is_turn && !turn_q)     observe(EV_TURN);
        end
        fault_q = fault;
        turn_q  = is_turn;
    end

    // Plant: crossing counter and line sensors driven from the per-step plan.
    int xc = 0, fcyc = 0, tcyc = -1;
    always @(negedge clk) begin
        int  ps;
        int  v;
        bit  ready;
        ready = 1'b0;
        if (reset) begin
            xc = 0; tcyc = -1;
        end else begin
            if (reset_crossing_counter) begin
                pstep++; xc = 0; fcyc = 0;
            end else if (reset_station) begin
                xc = 1;
            end
            ps = (pstep < 0) ? 0 : ((pstep >= DEPTH) ? DEPTH - 1 : pstep);
            if (drive_cmd == 3'd1 && !reset_crossing_counter) begin
                fcyc++;
                if ((fcyc % pg[ps]) == 0 && xc < 3) xc++;
            end
            if (drive_cmd == 3'd2 || drive_cmd == 3'd3) begin
                tcyc++;
                ready = (pd[ps] < NEVER) && (tcyc >= pd[ps]);
            end else begin
                tcyc = -1;
            end
        end
        if (ready) begin
            v = 5;
        end else if (tcyc >= 0 && pd[(pstep < 0) ? 0 : ((pstep >= DEPTH) ? DEPTH - 1 : pstep)] >= NEVER) begin
            v = 0;
        end else begin
            v = $urandom_range(0, 6);
            if (v >= 5) v++;
        end
        {sensor_l, sensor_m, sensor_r} = 3'(v);
        crossing_counter = 2'(xc);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check_reset_vals(string name);
        check(name, int'({drive_cmd, step_idx, busy, done, fault, load_ready,
                          reset_crossing_counter, reset_station}),
              int'({3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}));
    endtask

    task automatic load_step(logic [3:0] d);
        int exp_ready;
        exp_ready = (mroute.size() < DEPTH) ? 1 : 0;
        check("load_ready", int'(load_ready), exp_ready);
        load_valid = 1'b1;
        load_data  = d;
        tick();
        load_valid = 1'b0;
        if (exp_ready == 1) mroute.push_back(d);
    endtask

    task automatic clear();
        clear_route = 1'b1;
        tick();
        clear_route = 1'b0;
        mroute.delete();
    endtask

    // Reference model: expected event timeline from route + plan.
    task automatic run_route();
        int         s, t, b, e, eff, n;
        logic [3:0] st;
        bit         faulted;
        faulted = 1'b0;
        n = mroute.size();
        pstep = -1;
        start = 1'b1;
        s = cyc;
        t = s + 1;
        for (int i = 0; i < n && !faulted; i++) begin
            st  = mroute[i];
            eff = (st[1:0] == 2'd0) ? 1 : int'(st[1:0]);
            push(EV_ARM, t, i, 1, 1'b1);
            b = t + 1 + eff * pg[i];
            case (st[3:2])
                2'd0: t = b;
                2'd1, 2'd2: begin
                    push(EV_TURN, b, i, (st[3:2] == 2'd1) ? 2 : 3, 1'b1);
                    e = (pd[i] > TURN_MIN) ? pd[i] : TURN_MIN;
                    if (e > TURN_MAX - 1) begin
                        push(EV_FAULT, b + TURN_MAX, i, 0, 1'b0);
                        faulted = 1'b1;
                    end else begin
                        t = b + e + 1;
                    end
                end
                default: begin
                    push(EV_STN, b + STOP_CYCLES - 1, i, 4, 1'b1);
                    t = b + STOP_CYCLES;
                end
            endcase
        end
        if (!faulted) push(EV_DONE, t, 0, 0, 1'b1);
        tick();
        start = 1'b0;
    endtask

    task automatic drain(string name, int budget);
        int k;
        k = 0;
        while (expq.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        n_vec++;
        if (expq.size() != 0) begin
            n_miss++;
            $display("FAIL drain_%s: got %0d events pending after %0d cycles, required 0",
                     name, expq.size(), budget);
            expq.delete();
        end
    endtask

    task automatic finish_run(string name);
        drain(name, 400);
        tick();
        tick();
        check({"idle_after_", name}, int'({busy, drive_cmd}), 0);
    endtask

    task automatic random_plan();
        for (int i = 0; i < DEPTH; i++) begin
            pg[i] = $urandom_range(1, 3);
            pd[i] = $urandom_range(0, 9);
        end
    endtask

    initial begin
        int         s;
        logic [3:0] d;

        for (int i = 0; i < DEPTH; i++) begin pg[i] = 1; pd[i] = 0; end
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_reset_vals("reset_values");
        mon_en = 1'b1;

        // Empty route: straight to FINISH.
        run_route();
        finish_run("empty");

        // Directed route: straight@2, left@1 (sensors early), station@1.
        load_step(4'b0010);
        load_step(4'b0101);
        load_step(4'b1101);
        pg[0] = 1; pg[1] = 1; pg[2] = 1; pd[1] = 2;
        run_route();
        finish_run("directed");

        // Replay the retained route with a different plant plan.
        pg[0] = 2; pg[1] = 3; pg[2] = 1; pd[1] = 7;
        run_route();
        finish_run("replay");

        // Clear, then start on an empty route again.
        clear();
        run_route();
        finish_run("cleared");

        // Overfill: DEPTH accepts, extra write refused.
        load_step(4'b0001);
        for (int i = 1; i < DEPTH; i++) begin
            d = 4'($urandom_range(0, 15));
            load_step(d);
        end
        load_step(4'b0100);
        tick();
        check("load_ready_full", int'(load_ready), 0);
        random_plan();
        run_route();
        finish_run("overfill");

        // start and load in the same cycle: load must be dropped.
        clear();
        load_step(4'b0001);
        pg[0] = 1;
        load_valid = 1'b1;
        load_data  = 4'b1101;
        run_route();
        load_valid = 1'b0;
        finish_run("start_vs_load");

        // Randomised routes.
        for (int r = 0; r < 10; r++) begin
            clear();
            s = $urandom_range(1, DEPTH);
            for (int i = 0; i < s; i++) begin
                d = 4'($urandom_range(0, 15));
                load_step(d);
            end
            random_plan();
            repeat ($urandom_range(0, 3)) tick();
            run_route();
            finish_run("random");
        end

        // Reset in the middle of a station dwell.
        clear();
        load_step(4'b1101);
        pg[0] = 1;
        pstep = -1;
        start = 1'b1;
        s = cyc;
        push(EV_ARM, s + 1, 0, 1, 1'b1);
        tick();
        start = 1'b0;
        while (cyc < s + 4) tick();
        check("in_station", int'(drive_cmd), 4);
        reset = 1'b1;
        tick();
        check_reset_vals("reset_mid_dwell");
        reset = 1'b0;
        mroute.delete();
        drain("mid_dwell", 20);
        repeat (STOP_CYCLES + 2) tick();
        run_route();
        finish_run("after_reset");

        // Turn timeout: RIGHT step with sensors held at 000.
        load_step(4'b1001);
        pg[0] = 1;
        pd[0] = NEVER;
        run_route();
        drain("fault", 400);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        check("fault_hold", int'({fault, busy, drive_cmd}), int'({1'b1, 1'b1, 3'd0}));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check_reset_vals("reset_after_fault");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
